// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU (alu_pipe and alu_mul_iter).
package alu_pkg;

    localparam int FLAG_W = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_SHL = 4'b0010,
        OP_SHR = 4'b0011,
        OP_AND = 4'b0100,
        OP_OR  = 4'b0101,
        OP_XOR = 4'b0110,
        OP_CMP = 4'b0111,
        OP_MUL = 4'b1001
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH steps in total.
// The first step is taken on the start edge, so o_done marks the cycle of the final step.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               w_last;

    assign w_last    = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
    assign o_busy    = r_busy;
    assign o_done    = w_last;
    assign o_product = r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_acc   <= i_b[0] ? {{WIDTH{1'b0}}, i_a} : '0;
            r_mcand <= {{(WIDTH-1){1'b0}}, i_a, 1'b0};
            r_mplr  <= i_b >> 1;
            r_cnt   <= CNT_W'(1);
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (r_mplr[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshake and {Z,N,C,V} flags.
// Define ALU_MUL_EN to build the iterative multiplier (opcode 1001) and its IDLE/BUSY/DONE FSM.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in0,
    input  logic [WIDTH-1:0]  in1,
    input  logic [SEL_W-1:0]  select,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out,
    output logic [FLAG_W-1:0] flags
);
    localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(WIDTH);

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_result;
    alu_flags_t       w_flags;
    logic             w_accept;
    logic             w_out_free;
    logic             w_load_alu;
    logic             w_load_mul;
    logic             w_is_mul;

    logic [WIDTH-1:0] r_out;
    alu_flags_t       r_flags;
    logic             r_out_valid;

    assign w_add = {1'b0, in0} + {1'b0, in1};
    assign w_sub = {1'b0, in0} - {1'b0, in1};

    always_comb begin
        w_result = in1;
        w_flags  = '0;
        case (select)
            OP_ADD: begin
                w_result  = w_add[WIDTH-1:0];
                w_flags.c = w_add[WIDTH];
                w_flags.v = (in0[WIDTH-1] == in1[WIDTH-1]) && (w_add[WIDTH-1] != in0[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                // The extra top bit of the widened difference is the borrow.
                w_result  = w_sub[WIDTH-1:0];
                w_flags.c = w_sub[WIDTH];
                w_flags.v = (in0[WIDTH-1] != in1[WIDTH-1]) && (w_sub[WIDTH-1] != in0[WIDTH-1]);
            end
            OP_SHL:  w_result = (in1 >= SH_LIM) ? '0 : (in0 << in1);
            OP_SHR:  w_result = (in1 >= SH_LIM) ? '0 : (in0 >> in1);
            OP_AND:  w_result = in0 & in1;
            OP_OR:   w_result = in0 | in1;
            OP_XOR:  w_result = in0 ^ in1;
            default: w_result = in1;
        endcase
        w_flags.z = (w_result == '0);
        w_flags.n = w_result[WIDTH-1];
    end

    assign w_out_free = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_load_alu = w_accept && !w_is_mul;

`ifdef ALU_MUL_EN
    alu_state_e         r_state;
    logic               w_mul_start;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    alu_flags_t         w_mul_flags;

    assign w_is_mul    = (select == SEL_W'(OP_MUL));
    assign w_mul_start = w_accept && w_is_mul;
    assign in_ready    = (r_state == ST_IDLE) && !w_mul_busy && w_out_free;
    assign w_load_mul  = (r_state == ST_DONE) && w_out_free;

    always_comb begin
        w_mul_flags   = '0;
        w_mul_flags.z = (w_product[WIDTH-1:0] == '0);
        w_mul_flags.n = w_product[WIDTH-1];
        w_mul_flags.c = (w_product[2*WIDTH-1:WIDTH] != '0);
    end

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (in0),
        .i_b       (in1),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );
`else
    assign w_is_mul   = 1'b0;
    assign in_ready   = w_out_free;
    assign w_load_mul = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef ALU_MUL_EN
            r_state     <= ST_IDLE;
`endif
            r_out       <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
`ifdef ALU_MUL_EN
            case (r_state)
                ST_IDLE: if (w_mul_start) r_state <= ST_BUSY;
                ST_BUSY: if (w_mul_done)  r_state <= ST_DONE;
                ST_DONE: if (w_out_free)  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            if (w_load_mul) begin
                r_out       <= w_product[WIDTH-1:0];
                r_flags     <= w_mul_flags;
                r_out_valid <= 1'b1;
            end else
`endif
            // A new result may replace one being drained in the same cycle.
            if (w_load_alu) begin
                r_out       <= w_result;
                r_flags     <= w_flags;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out       = r_out;
    assign flags     = r_flags;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16): directed cases plus a random handshake stream
// scored against an arithmetic reference model. Mul cases follow ALU_MUL_EN.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in0;
    logic [15:0] in1;
    logic [3:0]  select;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic [3:0]  flags;

    int nchk = 0;
    int nbad = 0;

    alu_pipe #(
        .WIDTH(16),
        .SEL_W(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {result[15:0], Z, N, C, V} from plain integer arithmetic.
    function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        longint ua, ub, sa, sb, full, sr, res;
        bit c, v;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        c = 0;
        v = 0;
        case (op)
            4'd0: begin
                full = ua + ub; res = full % 65536; c = (full > 65535);
                sr = sa + sb; v = (sr > 32767) || (sr < -32768);
            end
            4'd1, 4'd7: begin
                res = (ua - ub + 65536) % 65536; c = (ua < ub);
                sr = sa - sb; v = (sr > 32767) || (sr < -32768);
            end
            4'd2: res = (ub >= 16) ? 0 : (ua * (longint'(1) << ub)) % 65536;
            4'd3: res = (ub >= 16) ? 0 : ua / (longint'(1) << ub);
            4'd4: res = longint'(a & b);
            4'd5: res = longint'(a | b);
            4'd6: res = longint'(a ^ b);
`ifdef ALU_MUL_EN
            4'd9: begin
                full = ua * ub; res = full % 65536; c = (full > 65535);
            end
`endif
            default: res = ub;
        endcase
        return {res[15:0], (res == 0), (res >= 32768), c, v};
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_out, input logic [3:0] exp_fl, input int exp_lat);
        int n;
        int lat;
        logic busy_rdy;
        in0 = a; in1 = b; select = op; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_accept"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        busy_rdy = 1'b0;
        while (!out_valid && lat < 60) begin
            if (in_ready) busy_rdy = 1'b1;
            @(posedge clk); #1; lat++;
        end
        chk({tag, "_out"}, out, exp_out);
        chk({tag, "_flags"}, flags, exp_fl);
        chk({tag, "_lat"}, lat, exp_lat);
        if (exp_lat > 1) chk({tag, "_busy_ready"}, busy_rdy, 0);
        $display("op %s sel=%0h a=%04h b=%04h -> out=%04h flags=%04b lat=%0d", tag, op, a, b, out, flags, lat);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [19:0] exp_q[$];
        logic [19:0] e;
        logic        prev_stall;
        logic [15:0] prev_out;
        logic [3:0]  prev_fl;
        logic        any_valid;
        logic        acc;
        int          sent;
        int          got;
        int          cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in0 = '0; in1 = '0; select = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out", out, 0);
        chk("reset_flags", flags, 0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 1);

        run_op("add_13_4",   4'h0, 16'd13,   16'd4,   16'd17,   4'b0000, 1);
        run_op("add_ovf",    4'h0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1);
        run_op("add_carry",  4'h0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1);
        run_op("sub_4_13",   4'h1, 16'd4,    16'd13,  16'hFFF7, 4'b0110, 1);
        run_op("cmp_eq",     4'h7, 16'd5,    16'd5,   16'h0000, 4'b1000, 1);
        run_op("shl_13_4",   4'h2, 16'd13,   16'd4,   16'h00D0, 4'b0000, 1);
        run_op("shl_1_15",   4'h2, 16'h0001, 16'd15,  16'h8000, 4'b0100, 1);
        run_op("shr_by_16",  4'h3, 16'hABCD, 16'd16,  16'h0000, 4'b1000, 1);
        run_op("shr_by_15",  4'h3, 16'h8000, 16'd15,  16'h0001, 4'b0000, 1);
        run_op("pass_b",     4'hF, 16'h0001, 16'h1234, 16'h1234, 4'b0000, 1);
`ifdef ALU_MUL_EN
        run_op("mul_13_4",   4'h9, 16'd13,   16'd4,   16'd52,   4'b0000, 17);
        run_op("mul_wrap",   4'h9, 16'h0100, 16'h0100, 16'h0000, 4'b1010, 17);
`else
        run_op("sel9_pass",  4'h9, 16'd5,    16'h4321, 16'h4321, 4'b0000, 1);
`endif

        // Backpressure: result held, no acceptance, then drain and accept together.
        out_ready = 1'b0;
        in0 = 16'd3; in1 = 16'd4; select = 4'h0; in_valid = 1'b1;
        #1;
        chk("bp_first_ready", in_ready, 1);
        @(posedge clk); #1;
        in0 = 16'hF0F0; in1 = 16'h0FF0; select = 4'h6;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_out", out, 16'd7);
            chk("bp_hold_flags", flags, 4'b0000);
            chk("bp_hold_ready", in_ready, 0);
            $display("stall cycle %0d out=%04h flags=%04b in_ready=%0b", i, out, flags, in_ready);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_swap_valid", out_valid, 1);
        chk("bp_swap_out", out, 16'hFF00);
        chk("bp_swap_flags", flags, 4'b0100);
        $display("drain+accept out=%04h flags=%04b", out, flags);
        @(posedge clk); #1;
        chk("bp_empty", out_valid, 0);

        // Reset in the middle of an operation (a busy multiply when built).
`ifdef ALU_MUL_EN
        in0 = 16'd13; in1 = 16'd4; select = 4'h9;
`else
        in0 = 16'hFFFF; in1 = 16'h0001; select = 4'h0;
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_flags", flags, 0);
        chk("rst_mid_out", out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_ready", in_ready, 1);
        any_valid = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) any_valid = 1'b1;
        end
        chk("rst_mid_no_result", any_valid, 0);
        $display("reset mid-op: out_valid=%0b in_ready=%0b", out_valid, in_ready);
        out_ready = 1'b1;

        // Random stream with random backpressure against the reference model.
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0;
        prev_out = '0; prev_fl = '0;
        while ((sent < 1000 || exp_q.size() > 0 || out_valid) && cyc < 40000) begin
            if (!in_valid && sent < 1000 && $urandom_range(0, 9) < 8) begin
                in_valid = 1'b1;
                select   = 4'($urandom_range(0, 15));
                in0      = 16'($urandom);
                in1      = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            end
            out_ready = (sent >= 1000) ? 1'b1 : ($urandom_range(0, 9) < 7);
            #1;
            if (prev_stall) begin
                chk("rand_stable", {out_valid, out, flags}, {1'b1, prev_out, prev_fl});
            end
            acc = in_valid && in_ready;
            if (acc) begin
                exp_q.push_back(model(select, in0, in1));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_extra", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_res", {out, flags}, e);
                    $display("rand #%0d out=%04h flags=%04b exp=%04h/%04b", got, out, flags, e[19:4], e[3:0]);
                    got++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out = out;
            prev_fl = flags;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        chk("rand_lost", exp_q.size(), 0);
        chk("rand_count", got, 1000);

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
